control_sequencer: RTL
======================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have no parameters; opcode map and latencies are fixed by this document.
REQ-002 Ports SHALL be, clock and reset first, in this order:
- CLK  input  1  single clock; all state updates on rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- INSTRUCTION  input  32  instruction word; [31:24] opcode, [23:16] dest/offset, [15:8] src1, [7:0] src2/immediate.
- INSTR_VALID  input  1  INSTRUCTION is valid this cycle.
- INSTR_READY  output  1  sequencer can accept an instruction.
- ZERO  input  1  ALU zero flag, high when the adder output is 0.
- ALUOP  output  3  ALU SELECT code.
- READREG1, READREG2, WRITEREG  output  3 each  register-file addresses, taken from bits [10:8], [2:0] and [18:16].
- IMMEDIATE  output  8  INSTRUCTION[7:0] of the captured word.
- IMM_SEL  output  1  ALU DATA2 = IMMEDIATE instead of register.
- NEG_SEL  output  1  ALU DATA2 = two's complement of register.
- WRITEENABLE  output  1  one-cycle register-file write strobe.
- BRANCH_TAKEN  output  1  one-cycle PC-redirect strobe.
- OFFSET  output  8  signed word offset, INSTRUCTION[23:16].
- ILLEGAL  output  1  one-cycle strobe for an undecodable opcode.

Function
REQ-003 Opcode decode SHALL be: 00 loadi (ALUOP 000, IMM_SEL), 01 mov (000), 02 add (001), 03 sub (001, NEG_SEL), 04 and (010), 05 or (011), 06 j, 07 beq (001, NEG_SEL), 08 bne (001, NEG_SEL), 09 ror (100, IMM_SEL), 0A mult (101), 0B sra (110, IMM_SEL), 0C sl (111, IMM_SEL); any other opcode is illegal.
REQ-004 FSM states SHALL be IDLE, DECODE, EXEC, WB; IDLE->DECODE on INSTR_VALID && INSTR_READY, DECODE->EXEC always, EXEC->WB when the latency counter expires, WB->IDLE always.
REQ-005 INSTR_READY SHALL be 1 only in IDLE; INSTR_VALID in any other state is ignored and the word is not captured.
REQ-006 INSTRUCTION SHALL be captured into an internal register on the accepting edge; all decoded outputs derive from the captured word and hold stable from DECODE through WB.
REQ-007 EXEC length N SHALL be: 1 cycle for loadi, mov, and, or, ror, sra, sl, j; 2 cycles for add, sub, beq, bne; 3 cycles for mult.
REQ-008 For accept edge at cycle t, WB SHALL occupy cycle t+2+N and INSTR_READY SHALL return high at cycle t+3+N.
REQ-009 WRITEENABLE SHALL be high for exactly the WB cycle, and only for loadi, mov, add, sub, and, or, ror, mult, sra, sl.
REQ-010 ZERO SHALL be sampled on the final EXEC edge; BRANCH_TAKEN SHALL pulse in WB for j always, beq when sampled ZERO=1, and bne when sampled ZERO=0.
REQ-011 Illegal opcode SHALL skip EXEC (DECODE->WB), pulse ILLEGAL in WB, and assert neither WRITEENABLE nor BRANCH_TAKEN.
REQ-012 Outside DECODE..WB, ALUOP, IMM_SEL, NEG_SEL SHALL be 0; strobes are never high outside WB.

Reset
REQ-013 RESET_N low SHALL immediately force state IDLE, counter 0, captured word 0, and every output to 0, including INSTR_READY.
REQ-014 The first rising CLK after RESET_N deasserts SHALL set INSTR_READY to 1; no instruction is accepted on that edge.
REQ-015 Reset asserted mid-instruction SHALL abort it with no WRITEENABLE, BRANCH_TAKEN, or ILLEGAL pulse.

Configuration
REQ-016 Macro MULT_EN: when defined, opcode 0A decodes as mult per REQ-003/REQ-007; when undefined, 0A SHALL be illegal per REQ-011 and no 3-cycle path exists.

Verification
REQ-017 After reset, loadi 0x00_04_00_2A accepted at t -> WB at t+3, WRITEENABLE=1, WRITEREG=4, IMMEDIATE=0x2A, IMM_SEL=1, ALUOP=000; READY high at t+4.
REQ-018 add 0x02_01_02_03 -> ALUOP=001, READREG1=2, READREG2=3, WRITEENABLE only at t+4, READY back at t+5.
REQ-019 beq 0x07_FE_01_02 with ZERO=1 -> BRANCH_TAKEN at t+4 with OFFSET=0xFE, no WRITEENABLE; repeated with ZERO=0 -> no pulse.
REQ-020 Opcode 0x3F -> ILLEGAL pulse at t+2, no write or branch; 0x0A with MULT_EN off -> same result; with MULT_EN on -> WRITEENABLE at t+5.
REQ-021 INSTR_VALID held high with changing INSTRUCTION through EXEC -> only the word present on the accept edge executes; RESET_N pulsed low during EXEC of add -> all outputs 0 immediately, no WRITEENABLE.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle instruction sequencer (IDLE/DECODE/EXEC/WB) driving ALU and register-file controls.
// Optional feature: define MULT_EN to decode opcode 0x0A as a 3-cycle mult; otherwise 0x0A is illegal.
module control_sequencer (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [31:0] INSTRUCTION,
    input  logic        INSTR_VALID,
    output logic        INSTR_READY,
    input  logic        ZERO,
    output logic [2:0]  ALUOP,
    output logic [2:0]  READREG1,
    output logic [2:0]  READREG2,
    output logic [2:0]  WRITEREG,
    output logic [7:0]  IMMEDIATE,
    output logic        IMM_SEL,
    output logic        NEG_SEL,
    output logic        WRITEENABLE,
    output logic        BRANCH_TAKEN,
    output logic [7:0]  OFFSET,
    output logic        ILLEGAL
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DECODE = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_WB     = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  r_cnt;
    logic [31:0] r_instr;
    logic        r_ready;
    logic        r_zero;

    logic [1:0]  w_next;
    logic [2:0]  w_aluop;
    logic [1:0]  w_lat;
    logic        w_imm, w_neg, w_we, w_illegal, w_jump, w_beq, w_bne;
    logic        w_busy, w_wb, w_accept;

    // Decode the captured opcode; w_lat is the EXEC length minus one.
    always_comb begin
        w_aluop   = 3'b000;
        w_imm     = 1'b0;
        w_neg     = 1'b0;
        w_we      = 1'b0;
        w_lat     = 2'd0;
        w_illegal = 1'b0;
        w_jump    = 1'b0;
        w_beq     = 1'b0;
        w_bne     = 1'b0;
        case (r_instr[31:24])
            8'h00: begin w_imm = 1'b1; w_we = 1'b1; end
            8'h01: w_we = 1'b1;
            8'h02: begin w_aluop = 3'b001; w_we = 1'b1; w_lat = 2'd1; end
            8'h03: begin w_aluop = 3'b001; w_neg = 1'b1; w_we = 1'b1; w_lat = 2'd1; end
            8'h04: begin w_aluop = 3'b010; w_we = 1'b1; end
            8'h05: begin w_aluop = 3'b011; w_we = 1'b1; end
            8'h06: w_jump = 1'b1;
            8'h07: begin w_aluop = 3'b001; w_neg = 1'b1; w_beq = 1'b1; w_lat = 2'd1; end
            8'h08: begin w_aluop = 3'b001; w_neg = 1'b1; w_bne = 1'b1; w_lat = 2'd1; end
            8'h09: begin w_aluop = 3'b100; w_imm = 1'b1; w_we = 1'b1; end
`ifdef MULT_EN
            8'h0A: begin w_aluop = 3'b101; w_we = 1'b1; w_lat = 2'd2; end
`endif
            8'h0B: begin w_aluop = 3'b110; w_imm = 1'b1; w_we = 1'b1; end
            8'h0C: begin w_aluop = 3'b111; w_imm = 1'b1; w_we = 1'b1; end
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_accept = (r_state == S_IDLE) && INSTR_VALID && r_ready;
    assign w_busy   = (r_state != S_IDLE);
    assign w_wb     = (r_state == S_WB);

    // Next state: illegal opcodes bypass EXEC straight to WB.
    always_comb begin
        w_next = (r_state == S_IDLE)   ? (w_accept ? S_DECODE : S_IDLE) :
                 (r_state == S_DECODE) ? (w_illegal ? S_WB : S_EXEC) :
                 (r_state == S_EXEC)   ? ((r_cnt == 2'd0) ? S_WB : S_EXEC) : S_IDLE;
    end

    // State, capture register, latency counter and branch flag; ready is registered so the first edge after reset only raises it.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
            r_instr <= 32'd0;
            r_ready <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next == S_IDLE);
            if (w_accept) r_instr <= INSTRUCTION;
            if (r_state == S_DECODE) r_cnt <= w_lat;
            else if (r_state == S_EXEC && r_cnt != 2'd0) r_cnt <= r_cnt - 2'd1;
            if (r_state == S_EXEC && r_cnt == 2'd0) r_zero <= ZERO;
        end
    end

    assign INSTR_READY  = r_ready;
    assign ALUOP        = w_busy ? w_aluop : 3'b000;
    assign IMM_SEL      = w_busy && w_imm;
    assign NEG_SEL      = w_busy && w_neg;
    assign WRITEENABLE  = w_wb && w_we;
    assign BRANCH_TAKEN = w_wb && (w_jump || (w_beq && r_zero) || (w_bne && !r_zero));
    assign ILLEGAL      = w_wb && w_illegal;
    assign READREG1     = r_instr[10:8];
    assign READREG2     = r_instr[2:0];
    assign WRITEREG     = r_instr[18:16];
    assign IMMEDIATE    = r_instr[7:0];
    assign OFFSET       = r_instr[23:16];
endmodule
